// File: rtl/input_conditioner.sv
// Input front-end for the lighting controller: synchronizes the button and PIR
// pins, debounces the button, classifies presses and qualifies motion.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 100000,
  parameter int LONG_PRESS_CYCLES = 150000000,
  parameter int PIR_MIN_CYCLES    = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infravermelho,
  output logic btn_level,
  output logic btn_press,
  output logic btn_short,
  output logic btn_long,
  output logic motion_level,
  output logic motion_start
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int PIR_W  = $clog2(PIR_MIN_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [PIR_W-1:0]  PIR_LAST  = PIR_W'(PIR_MIN_CYCLES - 1);
  localparam logic [PIR_W-1:0]  PIR_FULL  = PIR_W'(PIR_MIN_CYCLES);

  // Bit 0 = button, bit 1 = PIR; each gets its own two-flop synchronizer.
  logic [1:0] raw_in;
  logic [1:0] sync_out;

  assign raw_in = {infravermelho, push_button};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= raw_in[gi];
          s2_reg <= s1_reg;
        end
      end

      assign sync_out[gi] = s2_reg;
    end
  endgenerate

  logic btn_s2;
  logic pir_s2;

  assign btn_s2 = sync_out[0];
  assign pir_s2 = sync_out[1];

  // Button debounce: the level flips only after a run of DEBOUNCE_CYCLES differing samples.
  logic [DEB_W-1:0] deb_cnt_reg;
  logic             btn_level_reg;
  logic             btn_press_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_reg   <= '0;
      btn_level_reg <= 1'b0;
      btn_press_reg <= 1'b0;
    end else begin
      btn_press_reg <= 1'b0;
      if (btn_s2 == btn_level_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        btn_level_reg <= btn_s2;
        btn_press_reg <= btn_s2;
        deb_cnt_reg   <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
    end
  end

  // Press classifier: exactly one short or long event per debounced press.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } press_state_t;

  press_state_t      state_reg;
  press_state_t      state_next;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic              btn_short_reg;
  logic              btn_short_next;
  logic              btn_long_reg;
  logic              btn_long_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      hold_cnt_reg  <= '0;
      btn_short_reg <= 1'b0;
      btn_long_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      btn_short_reg <= btn_short_next;
      btn_long_reg  <= btn_long_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hold_cnt_next  = hold_cnt_reg;
    btn_short_next = 1'b0;
    btn_long_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (btn_level_reg) begin
          state_next    = ST_PRESSED;
          hold_cnt_next = HOLD_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!btn_level_reg) begin
          btn_short_next = 1'b1;
          state_next     = ST_IDLE;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          btn_long_next = 1'b1;
          state_next    = ST_LONG;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      ST_LONG: begin
        if (!btn_level_reg) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Motion: rise needs PIR_MIN_CYCLES consecutive highs, any low drops it at once.
  logic [PIR_W-1:0] pir_cnt_reg;
  logic             motion_level_reg;
  logic             motion_start_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pir_cnt_reg      <= '0;
      motion_level_reg <= 1'b0;
      motion_start_reg <= 1'b0;
    end else begin
      motion_start_reg <= 1'b0;
      if (!pir_s2) begin
        pir_cnt_reg      <= '0;
        motion_level_reg <= 1'b0;
      end else if (motion_level_reg) begin
        pir_cnt_reg <= PIR_FULL;
      end else if (pir_cnt_reg == PIR_LAST) begin
        pir_cnt_reg      <= PIR_FULL;
        motion_level_reg <= 1'b1;
        motion_start_reg <= 1'b1;
      end else begin
        pir_cnt_reg <= pir_cnt_reg + 1'b1;
      end
    end
  end

  assign btn_level    = btn_level_reg;
  assign btn_press    = btn_press_reg;
  assign btn_short    = btn_short_reg;
  assign btn_long     = btn_long_reg;
  assign motion_level = motion_level_reg;
  assign motion_start = motion_start_reg;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: a per-cycle vector table for reset,
// bounce, PIR glitch and simultaneous inputs, plus press-classification sequences.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push_button = 1'b1;
  logic infravermelho = 1'b1;
  logic btn_level;
  logic btn_press;
  logic btn_short;
  logic btn_long;
  logic motion_level;
  logic motion_start;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(10),
    .PIR_MIN_CYCLES   (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_button  (push_button),
    .infravermelho(infravermelho),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_short    (btn_short),
    .btn_long     (btn_long),
    .motion_level (motion_level),
    .motion_start (motion_start)
  );

  // exp = {btn_level, btn_press, btn_short, btn_long, motion_level, motion_start}
  typedef struct {
    logic       r;
    logic       pb;
    logic       pir;
    logic [5:0] exp;
    int         seg;
  } vec_t;

  vec_t vecs[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int press_n, short_n, long_n, level_hi, press_at, long_at;

  function automatic void add(input logic r, input logic pb, input logic pir,
                              input logic [5:0] exp, input int n, input int seg);
    vec_t v;
    v.r   = r;
    v.pb  = pb;
    v.pir = pir;
    v.exp = exp;
    v.seg = seg;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  function automatic void clear_counts();
    press_n  = 0;
    short_n  = 0;
    long_n   = 0;
    level_hi = 0;
    press_at = -1;
    long_at  = -1;
  endfunction

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (btn_press === 1'b1) begin press_n++; press_at = cyc; end
    if (btn_short === 1'b1) short_n++;
    if (btn_long === 1'b1) begin long_n++; long_at = cyc; end
    if (btn_level === 1'b1) level_hi++;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  initial begin
    logic [5:0] outs;

    // seg 1: reset with both inputs high, then re-qualification
    add(1, 1, 1, 6'b000000, 3, 1);
    add(0, 1, 1, 6'b000000, 4, 1);
    add(0, 1, 1, 6'b000011, 1, 1);
    add(0, 1, 1, 6'b110010, 1, 1);
    add(0, 1, 1, 6'b100010, 1, 1);
    // seg 2: reset mid-press discards state, no pulses
    add(1, 1, 1, 6'b000000, 2, 2);
    add(0, 0, 0, 6'b000000, 8, 2);
    // seg 3: bounce 1,0,1,0 (2 cycles each) then a 9-cycle hold (short at the boundary)
    add(0, 1, 0, 6'b000000, 2, 3);
    add(0, 0, 0, 6'b000000, 2, 3);
    add(0, 1, 0, 6'b000000, 2, 3);
    add(0, 0, 0, 6'b000000, 2, 3);
    add(0, 1, 0, 6'b000000, 5, 3);
    add(0, 1, 0, 6'b110000, 1, 3);
    add(0, 1, 0, 6'b100000, 3, 3);
    add(0, 0, 0, 6'b100000, 5, 3);
    add(0, 0, 0, 6'b000000, 1, 3);
    add(0, 0, 0, 6'b001000, 1, 3);
    add(0, 0, 0, 6'b000000, 3, 3);
    // seg 4: PIR glitch 2 cycles, gap 2, then 20 cycles of motion
    add(0, 0, 1, 6'b000000, 2, 4);
    add(0, 0, 0, 6'b000000, 2, 4);
    add(0, 0, 1, 6'b000000, 4, 4);
    add(0, 0, 1, 6'b000011, 1, 4);
    add(0, 0, 1, 6'b000010, 15, 4);
    add(0, 0, 0, 6'b000010, 2, 4);
    add(0, 0, 0, 6'b000000, 3, 4);
    // seg 5: both inputs rise on the same edge
    add(0, 1, 1, 6'b000000, 4, 5);
    add(0, 1, 1, 6'b000011, 1, 5);
    add(0, 1, 1, 6'b110010, 1, 5);
    add(0, 1, 1, 6'b100010, 1, 5);
    add(0, 0, 0, 6'b100010, 2, 5);
    add(0, 0, 0, 6'b100000, 3, 5);
    add(0, 0, 0, 6'b000000, 1, 5);
    add(0, 0, 0, 6'b001000, 1, 5);
    add(0, 0, 0, 6'b000000, 3, 5);

    clear_counts();
    foreach (vecs[i]) begin
      rst           = vecs[i].r;
      push_button   = vecs[i].pb;
      infravermelho = vecs[i].pir;
      tick();
      outs = {btn_level, btn_press, btn_short, btn_long, motion_level, motion_start};
      tests_run++;
      if (outs !== vecs[i].exp) begin
        tests_failed++;
        $display("FAIL vec%0d seg%0d: outputs=%b expected=%b", i, vecs[i].seg, outs, vecs[i].exp);
      end else begin
        $display("vec%0d seg%0d in=%b%b%b out=%b ok", i, vecs[i].seg,
                 vecs[i].r, vecs[i].pb, vecs[i].pir, outs);
      end
    end

    // Short press: 5-cycle hold
    clear_counts();
    push_button = 1'b1;
    observe(5);
    push_button = 1'b0;
    observe(20);
    check("short_press_count", press_n, 1);
    check("short_short_count", short_n, 1);
    check("short_long_count", long_n, 0);
    check("short_level_cycles", level_hi, 5);

    // Long press: 30-cycle hold, btn_long exactly 10 cycles after btn_press
    clear_counts();
    push_button = 1'b1;
    observe(30);
    push_button = 1'b0;
    observe(20);
    check("long_press_count", press_n, 1);
    check("long_long_count", long_n, 1);
    check("long_short_count", short_n, 0);
    check("long_delay", long_at - press_at, 10);

    // Reset while in LONG with the button still held
    clear_counts();
    push_button = 1'b1;
    observe(20);
    check("rl_first_long", long_n, 1);
    clear_counts();
    rst = 1'b1;
    observe(2);
    check("rl_pulses_in_reset", press_n + short_n + long_n, 0);
    check("rl_level_in_reset", int'(btn_level), 0);
    rst = 1'b0;
    clear_counts();
    observe(20);
    check("rl_press_latency", press_at, cyc - 20 + 6);
    check("rl_press_count", press_n, 1);
    check("rl_long_delay", long_at - press_at, 10);
    push_button = 1'b0;
    observe(20);
    check("rl_short_count", short_n, 0);
    check("rl_long_count", long_n, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
